// File: rtl/rr_stage_arbiter_if.sv
// Requester-side and downstream-side handshake bundle for rr_stage_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface rr_stage_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_W-1:0]               out_id;
    logic                          out_ready;
    logic [15:0]                   xfer_count;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, xfer_count
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, xfer_count
    );
endinterface

// File: rtl/rr_stage_arbiter.sv
// Round-robin N:1 arbiter feeding a single registered output stage; 1-cycle latency.
// Backpressure: req_ready is gated by stage_free, so a stalled output holds every requester.
module rr_stage_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_stage_arbiter_if.slave bus
);
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]       out_id_q, out_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]           xfer_count_q, xfer_count_d;

    logic                  stage_free;
    logic                  found;
    logic                  grant;
    logic                  xfer;
    logic [ID_W-1:0]       win;
    int                    idx;

    always_comb begin
        stage_free = !out_valid_q || bus.out_ready;
        found      = 1'b0;
        win        = '0;
        idx        = 0;
        // Scan from the pointer upward, wrapping explicitly so non-power-of-two counts work.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        grant = found && stage_free && rst_n;
        xfer  = out_valid_q && bus.out_ready;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        rr_ptr_d     = rr_ptr_q;
        xfer_count_d = xfer_count_q;

        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            out_id_d    = win;
            rr_ptr_d    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end else if (stage_free) begin
            out_valid_d = 1'b0;
        end

        if (xfer && xfer_count_q != 16'hFFFF) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            rr_ptr_q     <= '0;
            xfer_count_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            rr_ptr_q     <= rr_ptr_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.req_ready  = grant ? (NUM_REQ'(1) << win) : '0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;
    assign bus.xfer_count = xfer_count_q;
endmodule

// File: doc/rr_stage_arbiter.md
RR_STAGE_ARBITER -- requirements
Module: rr_stage_arbiter

Interface
REQ-001 Parameter DATA_WIDTH SHALL be: default 8, payload width per requester.
REQ-002 Parameter NUM_REQ SHALL be: default 4, number of requesters, legal range 2..16.
REQ-003 Parameter ID_W SHALL be: default $clog2(NUM_REQ), width of the source ID.
REQ-004 Port clk SHALL be: input, 1 bit, clock; all state updates on its rising edge.
REQ-005 Port rst_n SHALL be: input, 1 bit, reset, synchronous, active-low.
REQ-006 Port req_valid SHALL be: input, NUM_REQ bits, bit i high means requester i presents data.
REQ-007 Port req_data SHALL be: input, NUM_REQ*DATA_WIDTH bits, requester i payload in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_ready SHALL be: output, NUM_REQ bits, bit i high means requester i's payload is accepted this cycle.
REQ-009 Port out_valid SHALL be: output, 1 bit, registered output stage holds a payload.
REQ-010 Port out_data SHALL be: output, DATA_WIDTH bits, registered payload.
REQ-011 Port out_id SHALL be: output, ID_W bits, index of the requester that sourced out_data.
REQ-012 Port out_ready SHALL be: input, 1 bit, downstream accepts out_data this cycle.
REQ-013 Port xfer_count SHALL be: output, 16 bits, count of completed downstream transfers.

Function
REQ-014 A downstream transfer SHALL occur in any cycle where out_valid and out_ready are both high.
REQ-015 The output stage SHALL be able to load (stage_free) iff out_valid is low or out_ready is high.
REQ-016 Arbitration SHALL be round-robin: starting at pointer rr_ptr, the first index i (ascending, wrapping from NUM_REQ-1 to 0) with req_valid[i] high SHALL win.
REQ-017 req_ready SHALL be combinational and one-hot or zero: only the winner's bit is high, and only when stage_free is high.
REQ-018 When stage_free is low, req_ready SHALL be all zeros; requesters hold their data.
REQ-019 On a grant to winner w, at the next edge out_data SHALL equal req_data[w], out_id SHALL equal w, and out_valid SHALL be 1; latency is 1 cycle from acceptance.
REQ-020 On a grant to winner w, rr_ptr SHALL become (w+1) mod NUM_REQ.
REQ-021 With no grant, rr_ptr SHALL hold its value.
REQ-022 If stage_free is high and no req_valid bit is set, out_valid SHALL become 0 at the next edge.
REQ-023 In that case out_data and out_id SHALL hold their previous values.
REQ-024 While out_valid is high and out_ready is low, out_valid, out_data and out_id SHALL remain stable.
REQ-025 A transfer and a new grant in the same cycle SHALL be supported, giving full throughput of 1 payload per cycle with no bubble.
REQ-026 xfer_count SHALL increment by 1 on each transfer (REQ-014).
REQ-027 xfer_count SHALL saturate at 16'hFFFF.
REQ-028 A single continuously valid requester SHALL be granted every free cycle.
REQ-029 With all requesters continuously valid, grants SHALL rotate ptr, ptr+1, ...; no requester waits more than NUM_REQ free cycles.
REQ-030 req_valid deasserting without a grant SHALL be tolerated, with no side effects.

Reset
REQ-031 While rst_n is low at a clk edge: out_valid=0, out_data=0, out_id=0, rr_ptr=0, xfer_count=0.
REQ-032 While rst_n is low, req_ready SHALL be all zeros.
REQ-033 Reset mid-operation SHALL discard any held payload without counting it as a transfer.
REQ-034 First cycle after reset release: rr_ptr=0, so with all requesters valid, requester 0 SHALL win.

Verification
REQ-035 Reset, then req_valid=4'b1111 with data 0x10,0x11,0x12,0x13 and out_ready=1 -> out_id sequence 0,1,2,3,0, out_data 0x10..0x13, req_ready 4'b0001,0010,0100,1000.
REQ-036 Only req_valid[2]=1, data 0xA5, out_ready=1 for 3 cycles -> out_valid=1 every cycle from cycle 1, out_id=2, req_ready=4'b0100 each cycle, xfer_count=3.
REQ-037 out_valid=1 holding 0x11 (id 1), out_ready=0 for 4 cycles while req_valid=4'b1111 -> req_ready=0, output stable, xfer_count unchanged; on out_ready=1 -> next grant to id 2.
REQ-038 rr_ptr=3, req_valid=4'b1001 -> requester 3 granted, then rr_ptr wraps to 0 and requester 0 is granted next.
REQ-039 Reset asserted while out_valid=1 and out_ready=0 -> next edge out_valid=0, xfer_count=0, rr_ptr=0.
REQ-040 Preload xfer_count to 16'hFFFE (force), then 3 transfers -> xfer_count=16'hFFFF and holds.
